// File: rtl/spi_flash_reader.sv
// Read-only SPI flash window on the memory bus: one bus read becomes one SPI READ (SCK = clk/2, mode 0).
// Define SPI_FLASH_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy bits instead of READ (0x03).
module spi_flash_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_in,
  input  logic [31:0] address_in,
  input  logic        read_in,
  input  logic        write_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_mosi,
  input  logic        flash_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
`else
  localparam logic [7:0] OPCODE = 8'h03;
`endif

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE, WACK} state_t;

  state_t      state, state_next;
  logic        phase, phase_next;
  logic [5:0]  bit_cnt, bit_cnt_next;
  logic [31:0] tx_sr, tx_sr_next;
  logic [31:0] rx_sr, rx_sr_next;
  logic [5:0]  last_bit;
  state_t      follow;

  logic unused_ok;
  assign unused_ok = ^{write_mask_in, write_value_in, address_in[31:24], address_in[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 1'b0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_cnt <= bit_cnt_next;
      tx_sr   <= tx_sr_next;
      rx_sr   <= rx_sr_next;
    end
  end

  // Final bit index and successor for each shifting phase.
  always_comb begin
    last_bit = 6'd31;
    follow   = DONE;
    case (state)
      CMD:   begin last_bit = 6'd7;  follow = ADDR; end
`ifdef SPI_FLASH_FAST_READ_EN
      ADDR:  begin last_bit = 6'd23; follow = DUMMY; end
`else
      ADDR:  begin last_bit = 6'd23; follow = DATA; end
`endif
      DUMMY: begin last_bit = 6'd7;  follow = DATA; end
      default: begin last_bit = 6'd31; follow = DONE; end
    endcase
  end

  always_comb begin
    state_next     = state;
    phase_next     = phase;
    bit_cnt_next   = bit_cnt;
    tx_sr_next     = tx_sr;
    rx_sr_next     = rx_sr;
    ready_out      = 1'b0;
    read_value_out = '0;
    flash_csn      = 1'b1;
    flash_clk      = 1'b0;
    flash_mosi     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_in && read_in) begin
          state_next   = CMD;
          phase_next   = 1'b0;
          bit_cnt_next = '0;
          tx_sr_next   = {OPCODE, address_in[23:2], 2'b00};
        end else if (sel_in && write_in) begin
          state_next = WACK;
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        flash_csn  = 1'b0;
        flash_clk  = phase;
        flash_mosi = ((state == CMD) || (state == ADDR)) ? tx_sr[31] : 1'b0;
        phase_next = ~phase;
        // Bit boundary is the clk edge that ends the SCK-high half.
        if (phase) begin
          tx_sr_next = {tx_sr[30:0], 1'b0};
          if (state == DATA)
            rx_sr_next = {rx_sr[30:0], flash_miso};
          if (bit_cnt == last_bit) begin
            bit_cnt_next = '0;
            state_next   = follow;
          end else begin
            bit_cnt_next = bit_cnt + 6'd1;
          end
        end
      end
      DONE: begin
        ready_out      = 1'b1;
        // rx_sr holds bytes in arrival order; first byte lands in the low lane.
        read_value_out = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
        state_next     = IDLE;
      end
      WACK: begin
        ready_out  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash slave plus directed and randomized bus reads/writes.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam int HDR_BITS = 40;
  localparam int LAT = 145;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int HDR_BITS = 32;
  localparam int LAT = 129;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel_in = 1'b0;
  logic [31:0] address_in = '0;
  logic        read_in = 1'b0;
  logic        write_in = 1'b0;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic [31:0] read_value_out;
  logic        ready_out;
  logic        flash_clk;
  logic        flash_csn;
  logic        flash_mosi;
  logic        flash_miso = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  spi_flash_reader dut (
    .clk(clk), .reset(reset), .sel_in(sel_in), .address_in(address_in),
    .read_in(read_in), .write_in(write_in), .write_mask_in(write_mask_in),
    .write_value_in(write_value_in), .read_value_out(read_value_out),
    .ready_out(ready_out), .flash_clk(flash_clk), .flash_csn(flash_csn),
    .flash_mosi(flash_mosi), .flash_miso(flash_miso)
  );

  always #5 clk = ~clk;

  // Flash contents: explicit bytes, otherwise a fixed address pattern.
  logic [7:0] mem [int];

  function automatic logic [7:0] mbyte(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'(a * 13 + 7);
  endfunction

  // SPI flash slave model (mode 0).
  int          rise_cnt = 0;
  logic [39:0] mosi_bits = '0;
  logic [39:0] last_hdr = '0;
  int          k_bit;
  logic [39:0] hdr_shift;
  logic [7:0]  cur_byte;

  always @(posedge flash_clk or posedge flash_csn) begin
    if (flash_csn) begin
      rise_cnt  = 0;
      mosi_bits = '0;
    end else begin
      if (rise_cnt < HDR_BITS) mosi_bits = {mosi_bits[38:0], flash_mosi};
      rise_cnt++;
      if (rise_cnt == HDR_BITS) last_hdr = mosi_bits;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csn && rise_cnt >= HDR_BITS && rise_cnt < HDR_BITS + 32) begin
      k_bit     = rise_cnt - HDR_BITS;
      hdr_shift = mosi_bits >> (HDR_BITS - 32);
      cur_byte  = mbyte(int'(hdr_shift[23:0]) + k_bit / 8);
      flash_miso = cur_byte[7 - (k_bit % 8)];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic also_write, input string tag);
    logic [23:0] fa;
    logic [31:0] exp_word;
    logic [63:0] exp_hdr;
    logic [31:0] val;
    int ready_cyc;
    int pulses;
    logic csn_ok;
    fa        = a[23:0] & 24'hFFFFFC;
    exp_word  = {mbyte(int'(fa) + 3), mbyte(int'(fa) + 2), mbyte(int'(fa) + 1), mbyte(int'(fa))};
    exp_hdr   = {32'd0, OPC, fa};
    if (HDR_BITS == 40) exp_hdr = exp_hdr << 8;
    val       = '0;
    ready_cyc = -1;
    pulses    = 0;
    csn_ok    = 1'b1;
    @(posedge clk); #1;
    sel_in = 1'b1; read_in = 1'b1; write_in = also_write; address_in = a;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk); #1;
      if (k == 10) address_in = $urandom;
      if (ready_out) begin
        pulses++;
        if (ready_cyc < 0) begin ready_cyc = k; val = read_value_out; end
        sel_in = 1'b0; read_in = 1'b0; write_in = 1'b0;
      end
      if (flash_csn !== ((k < LAT) ? 1'b0 : 1'b1)) csn_ok = 1'b0;
    end
    sel_in = 1'b0; read_in = 1'b0; write_in = 1'b0;
    check({tag, "_ready_cycle"}, 64'(ready_cyc), 64'(LAT));
    check({tag, "_ready_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_data"}, 64'(val), 64'(exp_word));
    check({tag, "_csn_timing"}, 64'(csn_ok), 64'd1);
    check({tag, "_mosi_header"}, 64'(last_hdr), exp_hdr);
  endtask

  initial begin
    logic        quiet_ok;
    logic [31:0] ra;
    logic [23:0] rfa;

    repeat (3) @(posedge clk);
    #1;
    check("reset_csn", 64'(flash_csn), 64'd1);
    check("reset_sck", 64'(flash_clk), 64'd0);
    check("reset_mosi", 64'(flash_mosi), 64'd0);
    check("reset_ready", 64'(ready_out), 64'd0);
    check("reset_value", 64'(read_value_out), 64'd0);
    reset = 1'b0;

    mem[32'h104] = 8'h11; mem[32'h105] = 8'h22; mem[32'h106] = 8'h33; mem[32'h107] = 8'h44;
    do_read(32'h0000_0104, 1'b0, "rd104");
    do_read(32'hFF00_0106, 1'b0, "rd_hi_bits");

    // Write: acknowledged next cycle, no SPI activity.
    @(posedge clk); #1;
    sel_in = 1'b1; write_in = 1'b1; write_value_in = 32'hDEADBEEF; write_mask_in = 4'hF;
    address_in = 32'h0000_0104;
    @(posedge clk); #1;
    check("wr_ready", 64'(ready_out), 64'd1);
    check("wr_value", 64'(read_value_out), 64'd0);
    sel_in = 1'b0; write_in = 1'b0;
    quiet_ok = (flash_csn === 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (flash_csn !== 1'b1 || ready_out !== 1'b0) quiet_ok = 1'b0;
    end
    check("wr_quiet", 64'(quiet_ok), 64'd1);
    do_read(32'h0000_0104, 1'b0, "rd_after_wr");

    // Read request without select.
    read_in = 1'b1; sel_in = 1'b0; address_in = 32'h0000_0104;
    quiet_ok = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (flash_csn !== 1'b1 || ready_out !== 1'b0) quiet_ok = 1'b0;
    end
    read_in = 1'b0;
    check("nosel_quiet", 64'(quiet_ok), 64'd1);

    // Reset at cycle 50 of a read.
    @(posedge clk); #1;
    sel_in = 1'b1; read_in = 1'b1; address_in = 32'h0000_0104;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
    end
    check("pre_abort_csn", 64'(flash_csn), 64'd0);
    reset = 1'b1; sel_in = 1'b0; read_in = 1'b0;
    @(posedge clk); #1;
    check("abort_csn", 64'(flash_csn), 64'd1);
    check("abort_sck", 64'(flash_clk), 64'd0);
    check("abort_ready", 64'(ready_out), 64'd0);
    reset = 1'b0;
    quiet_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (flash_csn !== 1'b1 || ready_out !== 1'b0) quiet_ok = 1'b0;
    end
    check("abort_no_pulse", 64'(quiet_ok), 64'd1);
    do_read(32'h0000_0104, 1'b0, "rd_after_abort");

    // Simultaneous read and write is a read.
    do_read(32'h0000_0104, 1'b1, "rd_and_wr");

    // Randomized reads over random contents.
    for (int n = 0; n < 8; n++) begin
      ra  = $urandom;
      rfa = ra[23:0] & 24'hFFFFFC;
      for (int i = 0; i < 4; i++) mem[int'(rfa) + i] = 8'($urandom);
      do_read(ra, 1'($urandom_range(0, 1)), "rd_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
